// File: rtl/layer_pkg.sv
// Shared types and constants for the layer sequencer slice.
package layer_pkg;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_FEED    = 3'd1,
        S_GAP     = 3'd2,
        S_COLLECT = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;

    // Neuron needs IDLE->WAIT->MULT->WAIT1->ADD between consecutive inputs.
    localparam int unsigned MIN_INPUT_GAP = 5;

endpackage

// File: rtl/layer_sequencer_if.sv
// Upstream stream, neuron broadcast bus and downstream stream of one layer.
interface layer_sequencer_if
    import layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned NUM_NEURON = 4
);

    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            neu_in_data;
    logic                             neu_in_valid;
    logic [NUM_NEURON*DATA_WIDTH-1:0] neu_out;
    logic [NUM_NEURON-1:0]            neu_out_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;
    logic                             busy;
    logic                             err_timeout;

    // Sequencer side.
    modport slave (
        input  in_data, in_valid, neu_out, neu_out_valid, out_ready,
        output in_ready, neu_in_data, neu_in_valid, out_data, out_valid, out_last,
               busy, err_timeout
    );

    // Environment side: upstream producer, neuron array and downstream consumer.
    modport master (
        output in_data, in_valid, neu_out, neu_out_valid, out_ready,
        input  in_ready, neu_in_data, neu_in_valid, out_data, out_valid, out_last,
               busy, err_timeout
    );

endinterface

// File: rtl/result_capture.sv
// Latches per-neuron results and tracks which neurons have reported.
module result_capture
    import layer_pkg::*;
#(
    parameter int unsigned NUM_NEURON = 4,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] neu_out,
    input  logic [NUM_NEURON-1:0]            neu_out_valid,
    output logic [NUM_NEURON*DATA_WIDTH-1:0] res,
    output logic                             all_captured
);

    logic [NUM_NEURON-1:0]            mask_q;
    logic [NUM_NEURON*DATA_WIDTH-1:0] res_q;

    // Capture every reporting neuron; clearing also zeroes results so misses read as 0.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            mask_q <= '0;
            res_q  <= '0;
        end else if (enable) begin
            mask_q <= mask_q | neu_out_valid;
            for (int k = 0; k < int'(NUM_NEURON); k++) begin
                if (neu_out_valid[k]) begin
                    res_q[k*DATA_WIDTH +: DATA_WIDTH] <= neu_out[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign res          = res_q;
    // Includes bits arriving this cycle so the FSM can leave without an extra wait.
    assign all_captured = enable && (&(mask_q | neu_out_valid));

endmodule

// File: rtl/layer_sequencer.sv
// Buffers an input vector, broadcasts it to the neuron array, then streams results.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int unsigned NUM_INPUT  = 3,
    parameter int unsigned NUM_NEURON = 4,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned INPUT_GAP  = 5,
    parameter int unsigned TIMEOUT    = 64
) (
    input logic              clk,
    input logic              rst,
    layer_sequencer_if.slave bus
);

    localparam int unsigned MAX_CNT = (NUM_INPUT > NUM_NEURON) ? NUM_INPUT : NUM_NEURON;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned GAP_W   = $clog2(INPUT_GAP);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    if (INPUT_GAP < MIN_INPUT_GAP) begin : g_gap_check
        $error("INPUT_GAP is shorter than the neuron input cadence");
    end

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]                rd_cnt_q, rd_cnt_d;
    logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]                tmo_cnt_q, tmo_cnt_d;
    logic                            err_q, err_d;
    logic [DATA_WIDTH-1:0]           in_buf_q [NUM_INPUT];
    logic [NUM_NEURON*DATA_WIDTH-1:0] res;
    logic                            all_captured;
    logic                            cap_clear;
    logic [DATA_WIDTH-1:0]           feed_word;
    logic [DATA_WIDTH-1:0]           res_word;

    result_capture #(
        .NUM_NEURON (NUM_NEURON),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_capture (
        .clk           (clk),
        .rst           (rst),
        .clear         (cap_clear),
        .enable        (state_q == S_COLLECT),
        .neu_out       (bus.neu_out),
        .neu_out_valid (bus.neu_out_valid),
        .res           (res),
        .all_captured  (all_captured)
    );

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_LOAD;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    // Input vector buffer, written only while loading.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && bus.in_valid) begin
            for (int i = 0; i < int'(NUM_INPUT); i++) begin
                if (wr_cnt_q == CNT_W'(i)) begin
                    in_buf_q[i] <= bus.in_data;
                end
            end
        end
    end

    // Next-state logic for the load/feed/collect/drain sequence.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        cap_clear = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (wr_cnt_q == CNT_W'(NUM_INPUT - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = S_FEED;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FEED: begin
                gap_cnt_d = GAP_W'(INPUT_GAP - 1);
                state_d   = S_GAP;
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                // Leaving as the count hits 0 keeps pulses exactly INPUT_GAP apart.
                if (gap_cnt_q == GAP_W'(1)) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    state_d  = (rd_cnt_q == CNT_W'(NUM_INPUT - 1)) ? S_COLLECT : S_FEED;
                end
            end
            S_COLLECT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (all_captured) begin
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    rd_cnt_d = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_cnt_q == CNT_W'(NUM_NEURON - 1)) begin
                        rd_cnt_d  = '0;
                        tmo_cnt_d = '0;
                        cap_clear = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Word selection for the broadcast bus and the result stream.
    always_comb begin
        feed_word = '0;
        res_word  = '0;
        for (int i = 0; i < int'(NUM_INPUT); i++) begin
            if (rd_cnt_q == CNT_W'(i)) feed_word = in_buf_q[i];
        end
        for (int k = 0; k < int'(NUM_NEURON); k++) begin
            if (rd_cnt_q == CNT_W'(k)) res_word = res[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.in_ready     = (state_q == S_LOAD);
    assign bus.neu_in_valid = (state_q == S_FEED);
    assign bus.neu_in_data  = (state_q == S_FEED || state_q == S_GAP) ? feed_word : '0;
    assign bus.out_valid    = (state_q == S_DRAIN);
    assign bus.out_data     = (state_q == S_DRAIN) ? res_word : '0;
    assign bus.out_last     = (state_q == S_DRAIN) && (rd_cnt_q == CNT_W'(NUM_NEURON - 1));
    assign bus.busy         = !(state_q == S_LOAD && wr_cnt_q == '0);
    assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed and randomized checks of layer_sequencer against a transaction-level model.
module tb_layer_sequencer;

    localparam int NI  = 3;
    localparam int NN  = 4;
    localparam int DW  = 16;
    localparam int GAP = 5;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    layer_sequencer_if #(.DATA_WIDTH(DW), .NUM_NEURON(NN)) bus ();

    layer_sequencer #(
        .NUM_INPUT  (NI),
        .NUM_NEURON (NN),
        .DATA_WIDTH (DW),
        .INPUT_GAP  (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [DW-1:0] words [NI];
    logic [DW-1:0] nres  [NN];
    bit            err_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_vector();
        for (int i = 0; i < NI; i++) words[i] = DW'($urandom);
        for (int k = 0; k < NN; k++) nres[k] = DW'($urandom);
    endtask

    // One full vector: load, broadcast, neuron reports at COLLECT cycle s_k (0 = never), drain.
    task automatic run_vector(input int s0, input int s1, input int s2, input int s3,
                              input bit spurious, input bit hold_valid,
                              input int bp_word, input int bp_len);
        int            sched [NN];
        logic [DW-1:0] exp_out [NN];
        int            last;
        bit            tmo;
        int            c;
        int            bad;
        sched = '{s0, s1, s2, s3};
        last  = 0;
        tmo   = 1'b0;
        for (int k = 0; k < NN; k++) begin
            if (sched[k] == 0) tmo = 1'b1;
            else if (sched[k] > last) last = sched[k];
            exp_out[k] = (sched[k] != 0) ? nres[k] : '0;
        end

        for (int i = 0; i < NI; i++) begin
            int w = 0;
            bus.in_data  = words[i];
            bus.in_valid = 1'b1;
            while (bus.in_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("load_ready", 32'(bus.in_ready), 1);
            @(negedge clk);
        end
        if (hold_valid) bus.in_data = 16'hdead;
        else bus.in_valid = 1'b0;
        chk("feed_busy", 32'(bus.busy), 1);

        bad = 0;
        for (int i = 0; i < NI; i++) begin
            chk("feed_pulse", 32'(bus.neu_in_valid), 1);
            chk("feed_data", 32'(bus.neu_in_data), 32'(words[i]));
            if (bus.in_ready !== 1'b0) bad++;
            for (int g = 1; g < GAP; g++) begin
                @(negedge clk);
                if (spurious && i == 1 && g == 2) begin
                    bus.neu_out_valid = '1;
                    bus.neu_out       = {NN{16'hbad0}};
                end else begin
                    bus.neu_out_valid = '0;
                end
                if (bus.neu_in_valid !== 1'b0 || bus.neu_in_data !== words[i] ||
                    bus.in_ready !== 1'b0) bad++;
            end
            @(negedge clk);
        end
        bus.neu_out_valid = '0;
        chk("gap_hold", 32'(bad), 0);

        c   = 1;
        bad = 0;
        while (bus.out_valid !== 1'b1 && c < 200) begin
            if (bus.in_ready !== 1'b0) bad++;
            bus.neu_out_valid = '0;
            for (int k = 0; k < NN; k++) begin
                bus.neu_out[k*DW +: DW] = DW'($urandom);
                if (sched[k] == c) begin
                    bus.neu_out_valid[k]    = 1'b1;
                    bus.neu_out[k*DW +: DW] = nres[k];
                end
            end
            @(negedge clk);
            c++;
        end
        bus.neu_out_valid = '0;
        chk("drain_entry_cycle", 32'(c), tmo ? 32'(TMO + 1) : 32'(last + 1));
        if (tmo) err_exp = 1'b1;
        chk("err_timeout", 32'(bus.err_timeout), 32'(err_exp));

        for (int k = 0; k < NN; k++) begin
            if (k == bp_word) begin
                bus.out_ready = 1'b0;
                for (int b = 0; b < bp_len; b++) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out[k] ||
                        bus.out_last !== (k == NN - 1)) bad++;
                end
                bus.out_ready = 1'b1;
            end
            chk("out_valid", 32'(bus.out_valid), 1);
            chk("out_data", 32'(bus.out_data), 32'(exp_out[k]));
            chk("out_last", 32'(bus.out_last), 32'(k == NN - 1));
            if (bus.in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("stall_and_ready_low", 32'(bad), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.neu_out       = '0;
        bus.neu_out_valid = '0;
        bus.out_ready     = 1'b1;
        rst               = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_neu_in_valid", 32'(bus.neu_in_valid), 0);
        chk("rst_neu_in_data", 32'(bus.neu_in_data), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        rst = 1'b1;

        // Nominal vector with fixed words and neuron results.
        words = '{16'h0100, 16'h0200, 16'h0300};
        nres  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_vector(1, 1, 1, 1, 1'b0, 1'b0, -1, 0);

        // Backpressure on word 1.
        run_vector(2, 2, 2, 2, 1'b0, 1'b0, 1, 7);

        // Simultaneous then staggered reports.
        randomize_vector();
        run_vector(1, 4, 1, 4, 1'b0, 1'b0, -1, 0);

        // Upstream valid held high, spurious report during GAP.
        randomize_vector();
        run_vector(3, 1, 2, 5, 1'b1, 1'b1, -1, 0);

        // Neuron 3 silent: timeout, then the flag stays set for the next vector.
        randomize_vector();
        run_vector(2, 3, 1, 0, 1'b0, 1'b0, 3, 2);
        randomize_vector();
        run_vector(1, 2, 3, 4, 1'b0, 1'b0, -1, 0);

        // Reset while in GAP, then a fresh vector.
        randomize_vector();
        bus.in_valid = 1'b1;
        for (int i = 0; i < NI; i++) begin
            bus.in_data = words[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        err_exp = 1'b0;
        chk("midgap_rst_in_ready", 32'(bus.in_ready), 1);
        chk("midgap_rst_neu_in_valid", 32'(bus.neu_in_valid), 0);
        chk("midgap_rst_busy", 32'(bus.busy), 0);
        chk("midgap_rst_err", 32'(bus.err_timeout), 0);
        randomize_vector();
        run_vector(2, 1, 4, 3, 1'b0, 1'b0, -1, 0);

        // Random schedules and backpressure.
        for (int r = 0; r < 4; r++) begin
            randomize_vector();
            run_vector($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                       $urandom_range(1, 8), 1'b0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, NN - 1), $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controls one fully-connected layer built from NUM_NEURON neuron instances that share one input bus.
- Buffers an input vector of NUM_INPUT words, then broadcasts the words one at a time to all neurons, spacing them at the neuron's per-input cadence.
- Captures every neuron's sigmoid output, then streams the results downstream with a valid/ready handshake.
- Sits between the previous layer's output stream and the neuron array; chained layer_sequencers form the network.

Parameters:
- NUM_INPUT, 3, words per input vector; equals each neuron's numWeight.
- NUM_NEURON, 4, neurons in the layer.
- DATA_WIDTH, 16, width of input and output words.
- INPUT_GAP, 5, cycles from one neu_in_valid pulse to the next (≥5; neuron needs IDLE→WAIT→MULT→WAIT1→ADD).
- TIMEOUT, 64, cycles allowed in COLLECT before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-low (asserted when 0).
- in_data  in  DATA_WIDTH  upstream word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  accepting upstream words.
- neu_in_data  out  DATA_WIDTH  broadcast word to all neurons' myinput.
- neu_in_valid  out  1  single-cycle pulse to all neurons' myinputValid.
- neu_out  in  NUM_NEURON*DATA_WIDTH  neuron k output at bits [k*DW +: DW].
- neu_out_valid  in  NUM_NEURON  per-neuron outvalid pulses.
- out_data  out  DATA_WIDTH  result word, neuron 0 first.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream ready.
- out_last  out  1  high with the word from neuron NUM_NEURON-1.
- busy  out  1  high in any state except LOAD with 0 words buffered.
- err_timeout  out  1  sticky; set on COLLECT timeout, cleared only by reset.

Behaviour:
- Reset (rst=0 at a clk edge): state=LOAD; all counters 0; capture mask 0.
  - Outputs: in_ready=1, neu_in_valid=0, neu_in_data=0, out_valid=0, out_last=0, out_data=0, busy=0, err_timeout=0.
  - Reset mid-operation abandons the vector; the neurons are reset separately by the system.
- LOAD:
  - in_ready=1; each in_valid&in_ready cycle writes in_data to buf[wr_cnt] and increments wr_cnt.
  - When the word at index NUM_INPUT-1 is accepted: in_ready drops the next cycle, wr_cnt clears, go to FEED.
- FEED (1 cycle):
  - neu_in_data=buf[rd_cnt], neu_in_valid=1, gap counter loaded with INPUT_GAP-1, go to GAP.
- GAP:
  - neu_in_valid=0; neu_in_data held at buf[rd_cnt] for the whole gap (the neuron samples it in MULT).
  - When the gap counter reaches 0: rd_cnt++.
  - If rd_cnt was NUM_INPUT-1, go to COLLECT, otherwise back to FEED.
  - neu_in_valid pulses are therefore exactly INPUT_GAP cycles apart.
- COLLECT:
  - Any cycle with neu_out_valid[k]=1 latches neu_out slice k into res[k] and sets mask[k]. Several bits in the same cycle are all captured.
  - When mask is all ones (including the bit being set this cycle): go to DRAIN with rd_cnt=0.
  - The timeout counter increments each COLLECT cycle. At TIMEOUT: set err_timeout and go to DRAIN; results from uncaptured neurons are output as 0.
- neu_out_valid outside COLLECT is ignored and does not affect mask.
- DRAIN:
  - out_valid=1, out_data=res[rd_cnt], out_last=(rd_cnt==NUM_NEURON-1). out_data/out_last stay stable while out_valid&!out_ready.
  - On out_valid&out_ready: rd_cnt++. After the last word: clear mask, rd_cnt and timeout counter, go to LOAD with in_ready=1 the next cycle.
- No overlap: a new vector is not accepted until DRAIN completes (single buffer).
- Widths:
  - wr_cnt and rd_cnt use $clog2(max(NUM_INPUT,NUM_NEURON)+1) bits; the gap counter uses $clog2(INPUT_GAP) bits. No wrap-around is possible by construction.
  - buf is NUM_INPUT×DATA_WIDTH registers; res is NUM_NEURON×DATA_WIDTH.
- Corner cases:
  - NUM_INPUT=1: one FEED, then COLLECT.
  - NUM_NEURON=1: out_last is high on the only word.

Decomposition:
- Shared package (layer_pkg):
  - state encoding constants S_LOAD=0, S_FEED=1, S_GAP=2, S_COLLECT=3, S_DRAIN=4 (3-bit);
  - DATA_WIDTH default;
  - the minimum INPUT_GAP constant 5, which the top-level elaboration checks.
- One sub-module, result_capture: holds mask, res and the all-captured flag; inputs clear and enable.
- FSM, buffers and counters stay in layer_sequencer.

Test Plan:
1. Nominal:
   - Stimulus: rst low 2 cycles; load 3 words 0x0100, 0x0200, 0x0300 with neuron models.
   - Response: neu_in_valid pulses at cycles t, t+5, t+10 with matching data held stable; the models pulse outvalid with 0x1111..0x4444; out stream is 0x1111, 0x2222, 0x3333, 0x4444 with out_last only on 0x4444.
2. Backpressure:
   - Stimulus: out_ready low for 7 cycles during DRAIN word 1.
   - Response: out_data stays 0x2222 and out_valid stays high; no word is lost or duplicated.
3. Simultaneous and staggered outvalid:
   - Stimulus: neurons 0 and 2 pulse in the same cycle, 1 and 3 pulse 3 cycles later.
   - Response: all 4 are captured; DRAIN is entered the cycle after the last pulse.
4. Timeout:
   - Stimulus: neuron 3 never pulses.
   - Response: err_timeout=1 after 64 COLLECT cycles; out stream ends in 0x0000 with out_last=1; error stays set through the next vector.
5. Upstream flow:
   - Stimulus: in_valid held high continuously.
   - Response: exactly 3 words accepted, in_ready=0 until DRAIN finishes; a spurious neu_out_valid pulse during GAP does not set the mask.
6. Reset mid-GAP:
   - Stimulus: rst=0 for one cycle while in GAP.
   - Response: the next cycle shows in_ready=1, neu_in_valid=0, busy=0; a fresh vector completes correctly.
